// File: rtl/mem_arbiter.sv
// mem_arbiter: two-client (i-cache / d-cache) arbiter in front of a 64-bit
// burst memory. Each client transaction is one 256-bit line moved as four
// 64-bit beats. A single line register serves as the fill buffer for reads
// and the holding buffer for d-cache writebacks.
module mem_arbiter (
  input  logic         clk,
  input  logic         rst,
  // i-cache side
  input  logic         i_pmem_read,
  input  logic [31:0]  i_pmem_address,
  output logic [255:0] i_pmem_rdata,
  output logic         i_pmem_resp,
  // d-cache side
  input  logic         d_pmem_read,
  input  logic         d_pmem_write,
  input  logic [31:0]  d_pmem_address,
  input  logic [255:0] d_pmem_wdata,
  output logic [255:0] d_pmem_rdata,
  output logic         d_pmem_resp,
  // physical memory side
  output logic         pmem_read,
  output logic         pmem_write,
  output logic [31:0]  pmem_address,
  output logic [63:0]  pmem_wdata,
  input  logic [63:0]  pmem_rdata,
  input  logic         pmem_resp
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    I_READ  = 3'd1,
    D_READ  = 3'd2,
    D_WRITE = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t         state;
  logic [1:0]     beat_cnt;
  logic [1:0]     beat_nxt;
  logic [255:0]   line;
  logic           owner_d;     // client being served: 1 = d-cache, 0 = i-cache
  logic           last_tie_d;  // winner of the most recent contested grant
  logic           d_req;
  logic           tie;
  logic           grant_d;
  logic [31:0]    grant_addr;

  // Both clients read their fill line from the shared line register.
  assign i_pmem_rdata = line;
  assign d_pmem_rdata = line;

  // Grant decision for IDLE. The priority pointer only moves on contested
  // grants, so an uncontested grant does not disturb the alternation between
  // simultaneous requests. Reset value 0 means "i won last", so d wins first.
  always_comb begin
    d_req    = d_pmem_read | d_pmem_write;
    tie      = i_pmem_read & d_req;
    beat_nxt = beat_cnt + 2'd1;
    if (tie) begin
      grant_d = ~last_tie_d;
    end else begin
      grant_d = d_req;
    end
    if (grant_d) begin
      grant_addr = d_pmem_address & 32'hFFFF_FFE0;
    end else begin
      grant_addr = i_pmem_address & 32'hFFFF_FFE0;
    end
  end

  // Main FSM: arbitration, burst sequencing, line capture and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      beat_cnt     <= 2'd0;
      line         <= 256'd0;
      owner_d      <= 1'b0;
      last_tie_d   <= 1'b0;
      i_pmem_resp  <= 1'b0;
      d_pmem_resp  <= 1'b0;
      pmem_read    <= 1'b0;
      pmem_write   <= 1'b0;
      pmem_address <= 32'd0;
      pmem_wdata   <= 64'd0;
    end else begin
      case (state)
        IDLE: begin
          i_pmem_resp <= 1'b0;
          d_pmem_resp <= 1'b0;
          if (i_pmem_read || d_req) begin
            beat_cnt     <= 2'd0;
            owner_d      <= grant_d;
            pmem_address <= grant_addr;
            if (tie) begin
              last_tie_d <= grant_d;
            end
            if (grant_d && d_pmem_write) begin
              // Write takes precedence when the d-cache raises both strobes.
              state      <= D_WRITE;
              pmem_write <= 1'b1;
              line       <= d_pmem_wdata;
              pmem_wdata <= d_pmem_wdata[63:0];
            end else if (grant_d) begin
              state     <= D_READ;
              pmem_read <= 1'b1;
            end else begin
              state     <= I_READ;
              pmem_read <= 1'b1;
            end
          end
        end

        I_READ, D_READ: begin
          if (pmem_resp) begin
            line[{beat_cnt, 6'd0} +: 64] <= pmem_rdata;
            beat_cnt <= beat_nxt;
            if (beat_cnt == 2'd3) begin
              state       <= DONE;
              pmem_read   <= 1'b0;
              i_pmem_resp <= ~owner_d;
              d_pmem_resp <= owner_d;
            end
          end
        end

        D_WRITE: begin
          if (pmem_resp) begin
            beat_cnt <= beat_nxt;
            if (beat_cnt == 2'd3) begin
              state       <= DONE;
              pmem_write  <= 1'b0;
              d_pmem_resp <= 1'b1;
            end else begin
              // Present the next beat as soon as the current one is accepted.
              pmem_wdata <= line[{beat_nxt, 6'd0} +: 64];
            end
          end
        end

        DONE: begin
          i_pmem_resp <= 1'b0;
          d_pmem_resp <= 1'b0;
          state       <= IDLE;
        end

        default: begin
          state       <= IDLE;
          pmem_read   <= 1'b0;
          pmem_write  <= 1'b0;
          i_pmem_resp <= 1'b0;
          d_pmem_resp <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: table of single-client transactions plus
// hand-written sequences for tie arbitration, idle pmem_resp and mid-burst reset.
module tb_mem_arbiter;

  logic         clk;
  logic         rst;
  logic         i_pmem_read;
  logic [31:0]  i_pmem_address;
  logic [255:0] i_pmem_rdata;
  logic         i_pmem_resp;
  logic         d_pmem_read;
  logic         d_pmem_write;
  logic [31:0]  d_pmem_address;
  logic [255:0] d_pmem_wdata;
  logic [255:0] d_pmem_rdata;
  logic         d_pmem_resp;
  logic         pmem_read;
  logic         pmem_write;
  logic [31:0]  pmem_address;
  logic [63:0]  pmem_wdata;
  logic [63:0]  pmem_rdata;
  logic         pmem_resp;

  int checks;
  int errors;

  typedef struct {
    logic         i_rd;
    logic         d_rd;
    logic         d_wr;
    logic [31:0]  addr;
    logic [255:0] data;      // read beats from memory, or writeback line
    logic [7:0]   gaps;      // idle cycles before beat k in bits [2k+1:2k]
    logic [31:0]  exp_addr;
    logic         exp_wr;
    logic         exp_d;
  } vec_t;

  vec_t vecs [5];

  mem_arbiter dut (
    .clk            (clk),
    .rst            (rst),
    .i_pmem_read    (i_pmem_read),
    .i_pmem_address (i_pmem_address),
    .i_pmem_rdata   (i_pmem_rdata),
    .i_pmem_resp    (i_pmem_resp),
    .d_pmem_read    (d_pmem_read),
    .d_pmem_write   (d_pmem_write),
    .d_pmem_address (d_pmem_address),
    .d_pmem_wdata   (d_pmem_wdata),
    .d_pmem_rdata   (d_pmem_rdata),
    .d_pmem_resp    (d_pmem_resp),
    .pmem_read      (pmem_read),
    .pmem_write     (pmem_write),
    .pmem_address   (pmem_address),
    .pmem_wdata     (pmem_wdata),
    .pmem_rdata     (pmem_rdata),
    .pmem_resp      (pmem_resp)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Serve one burst whose request is already driven; drops the served client's request at resp.
  task automatic do_burst(input logic exp_d, input logic exp_wr, input logic [31:0] exp_addr,
                          input logic [255:0] data, input logic [7:0] gaps);
    int lat;
    int g;
    logic [63:0] beat;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!(pmem_read || pmem_write) && lat < 8);
    chk("grant latency", 256'(lat), 256'd1);
    chk("pmem_address", pmem_address, exp_addr);
    chk("pmem_write", pmem_write, exp_wr);
    chk("pmem_read", pmem_read, !exp_wr);
    for (int k = 0; k < 4; k++) begin
      beat = data[k*64 +: 64];
      g = int'(gaps[2*k +: 2]);
      for (int j = 0; j <= g; j++) begin
        if (j > 0) @(negedge clk);
        chk("request held", {pmem_read, pmem_write}, exp_wr ? 2'b01 : 2'b10);
        chk("address stable", pmem_address, exp_addr);
        if (exp_wr) chk("pmem_wdata beat", pmem_wdata, beat);
        pmem_resp  = (j == g);
        pmem_rdata = (j == g) ? beat : 64'hDEAD_BEEF_DEAD_BEEF;
      end
      @(negedge clk);
    end
    pmem_resp  = 1'b0;
    pmem_rdata = 64'd0;
    chk("i_pmem_resp at done", i_pmem_resp, !exp_d);
    chk("d_pmem_resp at done", d_pmem_resp, exp_d);
    chk("pmem request low in done", {pmem_read, pmem_write}, 2'b00);
    if (!exp_wr) chk("fill line", exp_d ? d_pmem_rdata : i_pmem_rdata, data);
    if (exp_d) begin
      d_pmem_read  = 1'b0;
      d_pmem_write = 1'b0;
    end else begin
      i_pmem_read = 1'b0;
    end
    @(negedge clk);
    chk("resp single pulse", {i_pmem_resp, d_pmem_resp}, 2'b00);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " pmem_read"}, pmem_read, 1'b0);
    chk({tag, " pmem_write"}, pmem_write, 1'b0);
    chk({tag, " pmem_address"}, pmem_address, 32'd0);
    chk({tag, " pmem_wdata"}, pmem_wdata, 64'd0);
    chk({tag, " resps"}, {i_pmem_resp, d_pmem_resp}, 2'b00);
    chk({tag, " line"}, i_pmem_rdata, 256'd0);
    chk({tag, " d line"}, d_pmem_rdata, 256'd0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    i_pmem_read = 1'b0;
    i_pmem_address = 32'd0;
    d_pmem_read = 1'b0;
    d_pmem_write = 1'b0;
    d_pmem_address = 32'd0;
    d_pmem_wdata = 256'd0;
    pmem_rdata = 64'd0;
    pmem_resp = 1'b0;

    vecs[0] = '{1'b1, 1'b0, 1'b0, 32'h0000_0064,
                {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                 64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111},
                8'h00, 32'h0000_0060, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 1'b0, 1'b1, 32'h0000_1000,
                {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
                 64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA},
                8'h89, 32'h0000_1000, 1'b1, 1'b1};
    vecs[2] = '{1'b0, 1'b1, 1'b1, 32'h0000_2004,
                {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                 64'h5555_AAAA_5555_AAAA, 64'h0F0F_F0F0_0F0F_F0F0},
                8'h04, 32'h0000_2000, 1'b1, 1'b1};
    vecs[3] = '{1'b0, 1'b1, 1'b0, 32'hABCD_EF1F,
                {64'h8888_0000_8888_0000, 64'h7777_0000_7777_0000,
                 64'h6666_0000_6666_0000, 64'h5555_0000_5555_0000},
                8'h45, 32'hABCD_EF00, 1'b0, 1'b1};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF,
                {64'hC0DE_0004_C0DE_0004, 64'hC0DE_0003_C0DE_0003,
                 64'hC0DE_0002_C0DE_0002, 64'hC0DE_0001_C0DE_0001},
                8'hC0, 32'hFFFF_FFE0, 1'b0, 1'b0};

    // Reset state
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;

    // Simultaneous requests right after reset: d first, then i
    i_pmem_read = 1'b1; i_pmem_address = 32'h0000_0100;
    d_pmem_read = 1'b1; d_pmem_address = 32'h0000_0200;
    do_burst(1'b1, 1'b0, 32'h0000_0200, {4{64'h0D0D_0D0D_0000_0001}}, 8'h00);
    do_burst(1'b0, 1'b0, 32'h0000_0100, {4{64'h0101_0101_0000_0002}}, 8'h00);

    // Second simultaneous pair: i first this time
    i_pmem_read = 1'b1; i_pmem_address = 32'h0000_0300;
    d_pmem_read = 1'b1; d_pmem_address = 32'h0000_0400;
    do_burst(1'b0, 1'b0, 32'h0000_0300, {4{64'h0303_0303_0000_0003}}, 8'h00);
    do_burst(1'b1, 1'b0, 32'h0000_0400, {4{64'h0404_0404_0000_0004}}, 8'h00);

    // pmem_resp while idle must have no effect
    pmem_resp = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("idle pmem_resp ignored", {pmem_read, pmem_write, i_pmem_resp, d_pmem_resp}, 4'b0000);
    end
    pmem_resp = 1'b0;

    // Table of single-client transactions
    for (int v = 0; v < 5; v++) begin
      i_pmem_read    = vecs[v].i_rd;
      d_pmem_read    = vecs[v].d_rd;
      d_pmem_write   = vecs[v].d_wr;
      i_pmem_address = vecs[v].addr;
      d_pmem_address = vecs[v].addr;
      d_pmem_wdata   = vecs[v].data;
      do_burst(vecs[v].exp_d, vecs[v].exp_wr, vecs[v].exp_addr, vecs[v].data, vecs[v].gaps);
    end

    // Reset after two beats of an i read
    i_pmem_read = 1'b1; i_pmem_address = 32'h0000_0500;
    @(negedge clk);
    chk("pre-reset pmem_read", pmem_read, 1'b1);
    pmem_resp = 1'b1; pmem_rdata = 64'h9999_0000_0000_0001;
    @(negedge clk);
    pmem_rdata = 64'h9999_0000_0000_0002;
    @(negedge clk);
    pmem_resp = 1'b0; pmem_rdata = 64'd0;
    #1 rst = 1'b1;
    #1 chk_all_zero("async reset");
    @(negedge clk);
    chk("no resp during reset", {i_pmem_resp, d_pmem_resp}, 2'b00);
    rst = 1'b0;
    do_burst(1'b0, 1'b0, 32'h0000_0500,
             {64'hE4E4_E4E4_E4E4_E4E4, 64'hE3E3_E3E3_E3E3_E3E3,
              64'hE2E2_E2E2_E2E2_E2E2, 64'hE1E1_E1E1_E1E1_E1E1}, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
- REQ-001 SHALL have no parameters; line = 256 bits, beat = 64 bits, 4 beats per line.
- REQ-002 SHALL have: clk  in  1  single clock, all state updates on rising edge.
- REQ-003 SHALL have: rst  in  1  asynchronous, active-high reset.
- REQ-004 SHALL have: i_pmem_read  in  1  i-cache line-fill request, held until i_pmem_resp.
- REQ-005 SHALL have: i_pmem_address  in  32  i-cache line address.
- REQ-006 SHALL have: i_pmem_rdata  out  256  fill line to i-cache.
- REQ-007 SHALL have: i_pmem_resp  out  1  i-cache completion pulse.
- REQ-008 SHALL have: d_pmem_read, d_pmem_write  in  1 each  d-cache fill / writeback request, held until d_pmem_resp.
- REQ-009 SHALL have: d_pmem_address  in  32  d-cache line address.
- REQ-010 SHALL have: d_pmem_wdata  in  256  writeback line.
- REQ-011 SHALL have: d_pmem_rdata  out  256  fill line to d-cache.
- REQ-012 SHALL have: d_pmem_resp  out  1  d-cache completion pulse.
- REQ-013 SHALL have: pmem_read, pmem_write  out  1 each  burst request to physical memory.
- REQ-014 SHALL have: pmem_address  out  32  burst base address, bits [4:0] always zero.
- REQ-015 SHALL have: pmem_wdata  out  64  current write beat.
- REQ-016 SHALL have: pmem_rdata  in  64  current read beat.
- REQ-017 SHALL have: pmem_resp  in  1  one beat transferred this cycle.

Function
- REQ-018 SHALL implement FSM states IDLE, I_READ, D_READ, D_WRITE, DONE.
- REQ-019 IDLE: SHALL sample requests; a pending request moves to the matching service state on the next edge, latching address (bits [4:0] forced to 0) and, for writes, d_pmem_wdata.
- REQ-020 Arbitration: when both i and d request in IDLE, SHALL grant the client not granted last; after reset d wins the first tie.
- REQ-021 When d_pmem_read and d_pmem_write are both high, SHALL treat the request as write (D_WRITE).
- REQ-022 Service states: SHALL hold pmem_read (I_READ/D_READ) or pmem_write (D_WRITE) high continuously and pmem_address stable until the 4th beat.
- REQ-023 SHALL keep a 2-bit beat counter, cleared on grant, incremented only on cycles with pmem_resp=1; beats may be non-consecutive.
- REQ-024 Read beat k SHALL be stored into line bits [64k+63:64k]; write beat k SHALL drive pmem_wdata = latched line bits [64k+63:64k].
- REQ-025 On the cycle pmem_resp=1 with counter=3, SHALL move to DONE; pmem_read/pmem_write SHALL be low in DONE.
- REQ-026 DONE: SHALL assert exactly one of i_pmem_resp/d_pmem_resp (the granted client) for exactly one cycle, with the full line stable on that client's rdata, then return to IDLE.
- REQ-027 i_pmem_rdata and d_pmem_rdata SHALL both be driven from the single line register; value is only meaningful during the respective resp.
- REQ-028 pmem_resp in IDLE or DONE SHALL be ignored.
- REQ-029 Client request changes during service SHALL be ignored until the next IDLE.
- REQ-030 Latency: request high in IDLE -> pmem request asserted next cycle; client resp one cycle after the 4th beat.

Reset
- REQ-031 rst=1 SHALL immediately (asynchronously) force IDLE, beat counter 0, last-grant=i (so d wins next tie), and all outputs 0 (resps, pmem_read, pmem_write, pmem_address, pmem_wdata, line register).
- REQ-032 Reset mid-burst SHALL abandon the burst with no client resp; service restarts from IDLE after release.

Verification
- REQ-033 i read alone, address 0x0000_0064, beats 0x11..11,0x22..22,0x33..33,0x44..44 on 4 consecutive resp cycles -> pmem_address=0x0000_0060, i_pmem_resp pulses once, i_pmem_rdata = {0x44..44,0x33..33,0x22..22,0x11..11}.
- REQ-034 d write address 0x0000_1000, wdata beats A,B,C,D with pmem_resp gapped (resp on cycles 2,5,6,9) -> pmem_wdata shows A,B,C,D in order, each held until its resp, d_pmem_resp one cycle after 4th resp.
- REQ-035 i and d read raised same cycle right after reset -> d served first, then i; second simultaneous pair -> i served first.
- REQ-036 d_pmem_read and d_pmem_write both high -> pmem_write=1, pmem_read=0 throughout.
- REQ-037 rst asserted after beat 2 of an i read -> all outputs 0 same cycle, no i_pmem_resp; after release with request still high, fresh 4-beat burst and single resp.
